// File: rtl/irrigation_pkg.sv
// Shared encodings for the irrigation scheduler: FSM states, soil-moisture codes, valve modes.
package irrigation_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_IRRIGATE = 3'b001,
    ST_REFILL   = 3'b010,
    ST_COOLDOWN = 3'b011,
    ST_FAULT    = 3'b100
  } state_t;

  typedef enum logic [1:0] {
    M_DRY     = 2'b00,
    M_OK      = 2'b01,
    M_INVALID = 2'b10,
    M_WET     = 2'b11
  } moisture_t;

  localparam logic MODE_SPRINKLER = 1'b0;
  localparam logic MODE_DRIP      = 1'b1;

endpackage

// File: rtl/moisture_debounce.sv
// Soil-moisture debouncer: a new code is accepted only after DEBOUNCE_CYCLES
// consecutive identical samples; any differing sample restarts the count.
module moisture_debounce
  import irrigation_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic [1:0] i_raw,
  output logic [1:0] o_debounced
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    r_sample;
  logic [1:0]    r_stable;
  logic [CW-1:0] r_count;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_sample <= M_OK;
      r_stable <= M_OK;
      r_count  <= '0;
    end else begin
      r_sample <= i_raw;
      if (i_raw == r_stable) begin
        r_count <= '0;
      end else if ((i_raw != r_sample) || (r_count == '0)) begin
        // first sample of a new candidate code
        if (DEBOUNCE_CYCLES == 1) begin
          r_stable <= i_raw;
          r_count  <= '0;
        end else begin
          r_count <= CW'(1);
        end
      end else if (r_count == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= i_raw;
        r_count  <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_debounced = r_stable;

endmodule

// File: rtl/irrigation_scheduler.sv
// Irrigation scheduler: drives the tank permit (yOut) and sprinkler/drip valves
// from the debounced soil sensor and the tank's water-available flag.
module irrigation_scheduler
  import irrigation_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH     = 8,
  parameter int unsigned MAX_ON_CYCLES   = 200,
  parameter int unsigned MIN_OFF_CYCLES  = 50,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   cIn,
  input  logic [1:0]             moistureRaw,
  input  logic                   modeSel,
  output logic                   yOut,
  output logic                   sprinklerValve,
  output logic                   dripValve,
  output logic                   fault,
  output logic [2:0]             stateOut,
  output logic [TIMER_WIDTH-1:0] timerValue
);

  localparam logic [TIMER_WIDTH-1:0] ON_LOAD  = TIMER_WIDTH'(MAX_ON_CYCLES);
  localparam logic [TIMER_WIDTH-1:0] OFF_LOAD = TIMER_WIDTH'(MIN_OFF_CYCLES);
  localparam logic [TIMER_WIDTH-1:0] ONE      = TIMER_WIDTH'(1);

  state_t                 r_state, w_state_next;
  logic [TIMER_WIDTH-1:0] r_timer, w_timer_next;
  logic                   r_mode, w_mode_next;
  logic [1:0]             w_moist;

  moisture_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock      (clock),
    .resetN     (resetN),
    .i_raw      (moistureRaw),
    .o_debounced(w_moist)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_mode  <= MODE_SPRINKLER;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      r_mode  <= w_mode_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_mode_next  = r_mode;
    unique case (r_state)
      ST_IDLE: begin
        if (w_moist == M_INVALID) begin
          w_state_next = ST_FAULT;
          w_timer_next = '0;
        end else if ((w_moist == M_DRY) && cIn) begin
          w_state_next = ST_IRRIGATE;
          w_timer_next = ON_LOAD;
          w_mode_next  = modeSel;
        end
      end
      ST_IRRIGATE: begin
        if (w_moist == M_INVALID) begin
          w_state_next = ST_FAULT;
          w_timer_next = '0;
        end else if ((w_moist == M_WET) || (r_timer == ONE)) begin
          w_state_next = ST_COOLDOWN;
          w_timer_next = OFF_LOAD;
        end else begin
          // the cycle that leaves for REFILL still spends one unit of budget
          w_timer_next = r_timer - ONE;
          if (!cIn) w_state_next = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (w_moist == M_INVALID) begin
          w_state_next = ST_FAULT;
          w_timer_next = '0;
        end else if (w_moist == M_WET) begin
          w_state_next = ST_COOLDOWN;
          w_timer_next = OFF_LOAD;
        end else if (cIn) begin
          w_state_next = ST_IRRIGATE;
        end
      end
      ST_COOLDOWN: begin
        if (w_moist == M_INVALID) begin
          w_state_next = ST_FAULT;
          w_timer_next = '0;
        end else if (r_timer == ONE) begin
          w_state_next = ST_IDLE;
          w_timer_next = '0;
        end else begin
          w_timer_next = r_timer - ONE;
        end
      end
      ST_FAULT: begin
        w_timer_next = '0;
        if (w_moist != M_INVALID) w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_timer_next = '0;
      end
    endcase
  end

  always_comb begin
    yOut           = 1'b1;
    sprinklerValve = 1'b0;
    dripValve      = 1'b0;
    fault          = 1'b0;
    unique case (r_state)
      ST_IRRIGATE: begin
        yOut           = 1'b0;
        sprinklerValve = (r_mode == MODE_SPRINKLER);
        dripValve      = (r_mode == MODE_DRIP);
      end
      ST_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign stateOut   = r_state;
  assign timerValue = r_timer;

endmodule
